// File: rtl/toe_pkg.sv
// Shared widths, error codes and lookup FSM states for the TOE connection table.
package toe_pkg;

  localparam int TUPLE_W = 192;
  localparam int KEY_W   = 96;
  localparam int ID_W    = 4;
  localparam int MAC_W   = 48;

  // Tuple layout MSB first: {srcmac, dstmac, key}; dstmac sits directly above the key.
  localparam int DSTMAC_LSB = KEY_W;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_DUP       = 2'b01;
  localparam logic [1:0] ERR_KILL_FREE = 2'b10;
  localparam logic [1:0] ERR_COLLIDE   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_t;

endpackage

// File: rtl/toe_tuple_ram.sv
// Connection tuple storage: one synchronous write port, one combinational read port.
module toe_tuple_ram
  import toe_pkg::*;
#(
  parameter int N_ENTRIES = 16
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ID_W-1:0]    waddr,
  input  logic [TUPLE_W-1:0] wdata,
  input  logic [ID_W-1:0]    raddr,
  output logic [TUPLE_W-1:0] rdata
);

  logic [TUPLE_W-1:0] mem [N_ENTRIES];

  // NOTE: storage is deliberately not reset; slot validity lives in the owner's valid mask.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/toe_conn_table.sv
// Connection table: install/kill slots and a sequential one-slot-per-cycle key lookup.
module toe_conn_table
  import toe_pkg::*;
#(
  parameter int N_ENTRIES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  input  logic [ID_W-1:0]      wr_id,
  input  logic [TUPLE_W-1:0]   wr_tuple,
  input  logic                 kill_valid,
  input  logic [ID_W-1:0]      kill_id,
  input  logic                 lk_valid,
  input  logic [KEY_W-1:0]     lk_key,
  output logic                 lk_ready,
  output logic                 rsp_valid,
  output logic                 rsp_hit,
  output logic [ID_W-1:0]      rsp_id,
  output logic [MAC_W-1:0]     rsp_dstmac,
  input  logic                 rsp_ready,
  output logic [N_ENTRIES-1:0] valid_mask,
  output logic [1:0]           err
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_ENTRIES - 1);

  state_t               state, state_nxt;
  logic [ID_W-1:0]      scan_idx, scan_idx_nxt;
  logic [KEY_W-1:0]     key_q;
  logic [N_ENTRIES-1:0] mask_nxt;
  logic [1:0]           err_nxt;
  logic [TUPLE_W-1:0]   rd_tuple;
  logic                 collide, install_ok, slot_match;
  logic                 hit_nxt;
  logic [ID_W-1:0]      id_nxt;
  logic [MAC_W-1:0]     mac_nxt;

  toe_tuple_ram #(.N_ENTRIES(N_ENTRIES)) u_ram (
    .clk   (clk),
    .we    (install_ok),
    .waddr (wr_id),
    .wdata (wr_tuple),
    .raddr (scan_idx),
    .rdata (rd_tuple)
  );

  // Same-slot install+kill resolves to the kill alone.
  assign collide    = wr_valid && kill_valid && (wr_id == kill_id);
  assign install_ok = wr_valid && !valid_mask[wr_id] && !collide;
  assign slot_match = valid_mask[scan_idx] && (rd_tuple[KEY_W-1:0] == key_q);

  assign lk_ready  = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mask_nxt = valid_mask;
    if (install_ok) mask_nxt[wr_id]  = 1'b1;
    if (kill_valid) mask_nxt[kill_id] = 1'b0;

    err_nxt = ERR_NONE;
    if (collide)                              err_nxt = ERR_COLLIDE;
    else if (kill_valid && !valid_mask[kill_id]) err_nxt = ERR_KILL_FREE;
    else if (wr_valid && valid_mask[wr_id])   err_nxt = ERR_DUP;
  end

  always_comb begin
    state_nxt    = state;
    scan_idx_nxt = scan_idx;
    hit_nxt      = rsp_hit;
    id_nxt       = rsp_id;
    mac_nxt      = rsp_dstmac;
    unique case (state)
      IDLE: if (lk_valid) begin
        state_nxt    = SCAN;
        scan_idx_nxt = '0;
      end
      SCAN: if (slot_match) begin
        state_nxt = RESP;
        hit_nxt   = 1'b1;
        id_nxt    = scan_idx;
        mac_nxt   = rd_tuple[DSTMAC_LSB +: MAC_W];
      end else if (scan_idx == LAST_IDX) begin
        state_nxt = RESP;
        hit_nxt   = 1'b0;
        id_nxt    = '0;
        mac_nxt   = '0;
      end else begin
        scan_idx_nxt = scan_idx + 1'b1;
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      scan_idx   <= '0;
      valid_mask <= '0;
      err        <= ERR_NONE;
      rsp_hit    <= 1'b0;
      rsp_id     <= '0;
      rsp_dstmac <= '0;
    end else begin
      state      <= state_nxt;
      scan_idx   <= scan_idx_nxt;
      valid_mask <= mask_nxt;
      err        <= err_nxt;
      rsp_hit    <= hit_nxt;
      rsp_id     <= id_nxt;
      rsp_dstmac <= mac_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (lk_ready && lk_valid) key_q <= lk_key;
  end

endmodule
